// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle for the iterative multiply/divide unit.
//   start/op/a/b            : operation request (requester -> unit)
//   busy/done/hi/lo/div_by_zero : status and result (unit -> requester)
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed/unsigned multiply and divide.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if slave port
//           op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//           MULT*: {hi,lo} = a*b ; DIV*: lo = quotient, hi = remainder
//           done pulses one cycle WIDTH+1 edges after the accepting edge.
// Signed operations run on magnitudes; signs are re-applied in FIX.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] opd_q, opd_d;         // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;     // product / quotient negative
    logic             neg_r_q, neg_r_d;     // remainder negative (dividend sign)
    logic             bzero_q, bzero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    // Operand conditioning at capture
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.a[WIDTH-1];
    assign b_neg     = signed_op & bus.b[WIDTH-1];
    assign a_mag     = a_neg ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    assign b_mag     = b_neg ? ({WIDTH{1'b0}} - bus.b) : bus.b;

    // Single-step datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic [PW-1:0]    prod, prod_neg;
    logic [WIDTH-1:0] rem_neg, quo_neg;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    // Partial remainder < divisor, so the shifted trial always fits WIDTH+1 bits.
    assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, opd_q};
    assign prod      = {acc_hi_q, acc_lo_q};
    assign prod_neg  = {PW{1'b0}} - prod;
    assign rem_neg   = {WIDTH{1'b0}} - acc_hi_q;
    assign quo_neg   = {WIDTH{1'b0}} - acc_lo_q;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        bzero_d  = bzero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = CALC;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    is_div_d = bus.op[1];
                    acc_lo_d = bus.op[1] ? a_mag : b_mag;
                    opd_d    = bus.op[1] ? b_mag : a_mag;
                    neg_q_d  = a_neg ^ b_neg;
                    neg_r_d  = a_neg;
                    bzero_d  = (bus.b == {WIDTH{1'b0}});
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_trial[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Divide by zero leaves the dividend magnitude as remainder;
                    // restoring its sign yields the original a.
                    hi_d  = neg_r_q ? rem_neg : acc_hi_q;
                    lo_d  = bzero_q ? {WIDTH{1'b1}} : (neg_q_q ? quo_neg : acc_lo_q);
                    dbz_d = bzero_q;
                end else begin
                    {hi_d, lo_d} = neg_q_q ? prod_neg : prod;
                    dbz_d        = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            bzero_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            bzero_q  <= bzero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are even and at least 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port op, input, 2 bits: operation select, with encodings 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplicand or dividend.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking hi/lo/div_by_zero updated.
REQ-010 The block SHALL have port hi, output, WIDTH bits: product upper half, or remainder.
REQ-011 The block SHALL have port lo, output, WIDTH bits: product lower half, or quotient.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: the last completed divide had b==0.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-014 The FSM SHALL leave IDLE for CALC only on an edge where start==1 in IDLE, capturing op, a and b at that edge (edge E0).
REQ-015 On capture, the block SHALL latch the operand magnitudes for signed ops and raw values for unsigned ops, record the result signs, and clear the iteration counter.
REQ-016 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, for exactly WIDTH steps.
REQ-017 After the WIDTH-th step, the FSM SHALL go to FIX.
REQ-018 FIX SHALL apply sign correction and register hi/lo/div_by_zero at edge E0+WIDTH+1, then go to DONE.
REQ-019 done SHALL be 1 for exactly the one cycle in DONE, following edge E0+WIDTH+1 (cycle 33 for WIDTH=32).
REQ-020 The FSM SHALL return from DONE to IDLE on the next edge.
REQ-021 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored in CALC, FIX and DONE, with no queuing.
REQ-023 Changes on a, b or op after E0 SHALL have no effect on the running operation.
REQ-024 MULT/MULTU SHALL produce the full 2*WIDTH-bit product, two's complement for MULT, with {hi,lo} = product.
REQ-025 DIV/DIVU SHALL set lo = quotient and hi = remainder.
REQ-026 DIV SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-027 Divide with b==0 SHALL set lo = all ones, hi = a and div_by_zero = 1, with the same latency as any other operation.
REQ-028 DIV of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no flag.
REQ-029 Multiply SHALL clear div_by_zero at its FIX.
REQ-030 hi, lo and div_by_zero SHALL hold their values between completions.
REQ-031 A back-to-back start SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-032 While rst_n==0, regardless of clk, the block SHALL force state to IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, and clear the counter and internal registers.
REQ-033 Reset asserted mid-operation SHALL abandon the operation; no done pulse and no result update SHALL follow.
REQ-034 After rst_n rises, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-035 The bench SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at E0+33, hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
REQ-036 The bench SHALL cover: MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 The bench SHALL cover: DIVU a=7, b=0 -> div_by_zero=1, hi=0x00000007, lo=0xFFFFFFFF; a following MULTU 2*3 -> div_by_zero=0, hi=0, lo=6.
REQ-038 The bench SHALL cover: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-039 The bench SHALL cover: start=1 held continuously with a and b changed every cycle -> exactly one done per WIDTH+3 cycles, each result matching operands sampled at its E0.
REQ-040 The bench SHALL cover: rst_n driven low at E0+10 between clock edges -> busy, hi and lo immediately 0; no done; a fresh DIVU 100/7 after release -> lo=14, hi=2.
